// File: rtl/sync_alu_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : sync_alu_arbiter_if
// Purpose  : Requester, ALU-side and response bundle for sync_alu_arbiter.
// Revision : 1.0
// =============================================================================
interface sync_alu_arbiter_if #(
    parameter int M = 32
);
    logic [1:0]          in_valid;
    logic [1:0][M-1:0]   in_A;
    logic [1:0][M-1:0]   in_B;
    logic [1:0][3:0]     in_op;
    logic [1:0]          on_ready;

    logic [M-1:0]        o_alu_A;
    logic [M-1:0]        o_alu_B;
    logic [3:0]          o_alu_op;
    logic [M-1:0]        i_alu_result;
    logic [3:0]          i_alu_status;

    logic                o_rsp_valid;
    logic                o_rsp_id;
    logic [M-1:0]        o_rsp_result;
    logic [3:0]          o_rsp_status;
    logic                i_rsp_ready;

    logic [7:0]          o_err_cnt;

    modport slave (
        input  in_valid, in_A, in_B, in_op, i_alu_result, i_alu_status, i_rsp_ready,
        output on_ready, o_alu_A, o_alu_B, o_alu_op,
        output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_err_cnt
    );

    modport master (
        output in_valid, in_A, in_B, in_op, i_alu_result, i_alu_status, i_rsp_ready,
        input  on_ready, o_alu_A, o_alu_B, o_alu_op,
        input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sync_alu_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sync_alu_arbiter
// Purpose  : Round-robin arbiter sharing one external ALU between two
//            requesters; fixed IDLE/ISSUE/WAIT/RESP sequence per operation.
//            Define ALU_ARB_ERRCNT_EN to enable the error-response counter.
// Revision : 1.0
// =============================================================================
module sync_alu_arbiter #(
    parameter int M = 32
) (
    input  wire logic           clk,
    input  wire logic           i_reset,
    sync_alu_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q;
    logic           last_q;
    logic           id_q;
    logic           rsp_valid_q;
    logic [M-1:0]   alu_a_q;
    logic [M-1:0]   alu_b_q;
    logic [3:0]     alu_op_q;
    logic [M-1:0]   rsp_result_q;
    logic [3:0]     rsp_status_q;

    logic           grant_vld_d;
    logic           grant_id_d;

    // Reset gates the grant so no ready strobe escapes while the FSM is held in IDLE.
    always_comb begin
        grant_vld_d = (state_q == IDLE) && !i_reset && (bus.in_valid != 2'b00);
        grant_id_d  = 1'b0;
        case (bus.in_valid)
            2'b01:   grant_id_d = 1'b0;
            2'b10:   grant_id_d = 1'b1;
            2'b11:   grant_id_d = ~last_q;
            default: grant_id_d = 1'b0;
        endcase
    end

    assign bus.on_ready = {grant_vld_d & grant_id_d, grant_vld_d & ~grant_id_d};

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        alu_a_q  <= bus.in_A[grant_id_d];
                        alu_b_q  <= bus.in_B[grant_id_d];
                        alu_op_q <= bus.in_op[grant_id_d];
                        id_q     <= grant_id_d;
                        last_q   <= grant_id_d;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    rsp_result_q <= bus.i_alu_result;
                    rsp_status_q <= bus.i_alu_status;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_alu_A      = alu_a_q;
    assign bus.o_alu_B      = alu_b_q;
    assign bus.o_alu_op     = alu_op_q;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_id     = id_q;
    assign bus.o_rsp_result = rsp_result_q;
    assign bus.o_rsp_status = rsp_status_q;

`ifdef ALU_ARB_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            err_cnt_q <= '0;
        end else if ((state_q == RESP) && bus.i_rsp_ready && rsp_status_q[3]
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.o_err_cnt = err_cnt_q;
`else
    assign bus.o_err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/sync_alu_arbiter.md
SYNC_ALU_ARBITER -- requirements
Module: sync_alu_arbiter

Interface
REQ-001 SHALL have parameter: M, 32, operand/result width of the shared ALU.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports, requester n in {0,1}: in_valid input 1 request; in_A, in_B input M operands; in_op input 4 ALU opcode; on_ready output 1 accept strobe.
REQ-005 SHALL have ALU-side ports: o_alu_A, o_alu_B output M; o_alu_op output 4; i_alu_result input M; i_alu_status input 4.
REQ-006 SHALL have response ports: o_rsp_valid output 1; o_rsp_id output 1 requester index; o_rsp_result output M; o_rsp_status output 4; i_rsp_ready input 1.
REQ-007 SHALL have port: o_err_cnt output 8 saturating count of error responses.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE: any in_valid high -> grant one requester, assert its on_ready combinationally, latch its operands/op into o_alu_* registers, store id, go ISSUE.
REQ-010 on_ready SHALL be high only in IDLE, only for the granted requester, at most one requester per cycle.
REQ-011 Arbitration SHALL be round-robin: only one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer updates on every accept.
REQ-012 ISSUE: o_alu_* held stable for the ALU sampling edge; go WAIT unconditionally.
REQ-013 WAIT: capture i_alu_result into o_rsp_result and i_alu_status into o_rsp_status; go RESP.
REQ-014 RESP: o_rsp_valid high; o_rsp_result/status/id stable until i_rsp_ready high, then IDLE next cycle.
REQ-015 Latency SHALL be fixed: o_rsp_valid rises exactly 3 cycles after the accept edge.
REQ-016 Back-pressure: i_rsp_ready low holds RESP indefinitely; no new request accepted.
REQ-017 Accepts occur only in IDLE; a request valid during RESP with i_rsp_ready high is accepted no earlier than the following IDLE cycle; peak throughput one op per 4 cycles.
REQ-018 Requesters SHALL hold in_valid and operands until on_ready; the block SHALL not sample requester operands outside the accept cycle.
REQ-019 o_alu_* SHALL keep their last values outside ISSUE/WAIT.
REQ-020 o_err_cnt SHALL increment by 1 on each RESP->IDLE handshake with o_rsp_status[3]=1, saturating at 255.

Reset
REQ-021 i_reset high SHALL immediately force state IDLE, all on_ready 0, o_rsp_valid 0, o_rsp_id 0, o_rsp_result 0, o_rsp_status 0, o_alu_A/B 0, o_alu_op 0, o_err_cnt 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-022 Reset mid-transaction SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-023 Macro ALU_ARB_ERRCNT_EN defined: o_err_cnt behaves per REQ-020.
REQ-024 Macro ALU_ARB_ERRCNT_EN undefined: counter logic absent; o_err_cnt tied to 0; all other behaviour identical.

Verification
REQ-025 Req0 alone, op=4'b0010, A=100, B=32'hFFFFFFFA -> on_ready0 one cycle; 3 cycles later o_rsp_valid=1, id=0, result=20, status=0.
REQ-026 Req0 and req1 valid together, held for 3 transactions after reset -> grant order 0,1,0; each response id matches.
REQ-027 i_rsp_ready low 10 cycles while req1 valid -> o_rsp_valid and data stable for 10 cycles, on_ready1 stays 0; accepted only after handshake.
REQ-028 op=4'b0010, B=32'hFFFFFFFF (divisor 0) -> status[3]=1; with ALU_ARB_ERRCNT_EN o_err_cnt=1, without it 0; 300 such ops -> 255.
REQ-029 Assert i_reset during WAIT -> outputs zero asynchronously, no response emitted; next tie grants requester 0.
